// File: rtl/ps2_mouse_packet_rx.sv
// ps2_mouse_packet_rx: PS/2 mouse receiver assembling 3-byte movement packets into deltas and buttons.
// Define PS2_PARITY_CHECK_EN to treat an odd-parity failure as a frame error.
module ps2_mouse_packet_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2c,
   input  logic       ps2d,
   input  logic       rx_en,
   output logic [8:0] xm,
   output logic [8:0] ym,
   output logic       left,
   output logic       right,
   output logic       middle,
   output logic       m_done_tick,
   output logic       err_tick
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [1:0] {IDLE, DPS, LOAD} byte_state_t;
   typedef enum logic [1:0] {B1, B2, B3} pkt_state_t;
   byte_state_t bs, bs_next;
   pkt_state_t ps, ps_next;
   logic [FILTER_LEN-1:0] filt;
   logic f_ps2c, f_ps2c_prev, fall_edge, timeout, frame_ok;
   logic [3:0] n, n_next;
   logic [10:0] b, b_next;
   logic [6:0] b1, b1_next;
   logic [7:0] bx, bx_next;
   logic [TW-1:0] tcnt, tcnt_next;
   logic [8:0] xm_next, ym_next;
   logic left_next, right_next, middle_next, done_next, err_next;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         filt        <= '1;
         f_ps2c      <= 1'b1;
         f_ps2c_prev <= 1'b1;
         fall_edge   <= 1'b0;
         bs          <= IDLE;
         ps          <= B1;
         n           <= '0;
         b           <= '0;
         b1          <= '0;
         bx          <= '0;
         tcnt        <= '0;
         xm          <= '0;
         ym          <= '0;
         left        <= 1'b0;
         right       <= 1'b0;
         middle      <= 1'b0;
         m_done_tick <= 1'b0;
         err_tick    <= 1'b0;
      end else begin
         filt        <= {filt[FILTER_LEN-2:0], ps2c};
         f_ps2c      <= &filt ? 1'b1 : ~|filt ? 1'b0 : f_ps2c;
         f_ps2c_prev <= f_ps2c;
         fall_edge   <= f_ps2c_prev & ~f_ps2c;
         bs          <= bs_next;
         ps          <= ps_next;
         n           <= n_next;
         b           <= b_next;
         b1          <= b1_next;
         bx          <= bx_next;
         tcnt        <= tcnt_next;
         xm          <= xm_next;
         ym          <= ym_next;
         left        <= left_next;
         right       <= right_next;
         middle      <= middle_next;
         m_done_tick <= done_next;
         err_tick    <= err_next;
      end

   // b holds {stop, parity, data[7:0], start}; b1 keeps byte-1 bits 7..4 and 2..0
   always_comb begin
      timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_PARITY_CHECK_EN
      frame_ok = ~b[0] & b[10] & ^b[9:1];
`else
      frame_ok = ~b[0] & b[10];
`endif
      bs_next     = bs;
      n_next      = n;
      b_next      = b;
      ps_next     = ps;
      b1_next     = b1;
      bx_next     = bx;
      xm_next     = xm;
      ym_next     = ym;
      left_next   = left;
      right_next  = right;
      middle_next = middle;
      done_next   = 1'b0;
      err_next    = 1'b0;
      tcnt_next   = (fall_edge || timeout || (bs == IDLE && ps == B1)) ? '0 : tcnt + 1'b1;
      if (timeout) begin
         bs_next  = IDLE;
         ps_next  = B1;
         err_next = 1'b1;
      end else begin
         case (bs)
            IDLE: if (fall_edge && rx_en && !ps2d) begin
               bs_next = DPS;
               n_next  = 4'd9;
               b_next  = {ps2d, b[10:1]};
            end
            DPS: if (fall_edge) begin
               b_next  = {ps2d, b[10:1]};
               bs_next = n == 4'd0 ? LOAD : DPS;
               n_next  = n == 4'd0 ? n : n - 4'd1;
            end
            default: bs_next = IDLE;
         endcase
         if (bs == LOAD) begin
            if (!frame_ok) begin
               ps_next  = B1;
               err_next = 1'b1;
            end else if (ps == B1) begin
               ps_next  = b[4] ? B2 : B1;
               err_next = ~b[4];
               b1_next  = b[4] ? {b[8:5], b[3:1]} : b1;
            end else if (ps == B2) begin
               ps_next = B3;
               bx_next = b[8:1];
            end else begin
               ps_next     = B1;
               done_next   = 1'b1;
               xm_next     = b1[5] ? (b1[3] ? 9'h100 : 9'h0FF) : {b1[3], bx};
               ym_next     = b1[6] ? (b1[4] ? 9'h100 : 9'h0FF) : {b1[4], b[8:1]};
               left_next   = b1[0];
               right_next  = b1[1];
               middle_next = b1[2];
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// tb_ps2_mouse_packet_rx: randomized and directed PS/2 packet stimulus checked against a packet-level model.
module tb_ps2_mouse_packet_rx;
   localparam int TO = 1500;
   localparam int HP = 15;
   localparam int GAP = 60;

   logic clk = 1'b0, reset = 1'b1, ps2c = 1'b1, ps2d = 1'b1, rx_en = 1'b1;
   logic [8:0] xm, ym;
   logic left, right, middle, m_done_tick, err_tick;

   int n_checks = 0, n_pass = 0;
   int done_cnt = 0, err_cnt = 0;
   int exp_done = 0, exp_err = 0, mpos = 0;
   logic [7:0] mb1, mbx;
   logic [8:0] exp_x = '0, exp_y = '0;
   logic [2:0] exp_btn = '0;

   ps2_mouse_packet_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
      .xm(xm), .ym(ym), .left(left), .right(right), .middle(middle),
      .m_done_tick(m_done_tick), .err_tick(err_tick)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (m_done_tick) done_cnt++;
      if (err_tick) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] delta(input logic ovf, input logic sign, input logic [7:0] v);
      int d;
      d = ovf ? (sign ? -256 : 255) : (sign ? int'(v) - 256 : int'(v));
      return d[8:0];
   endfunction

   function automatic void model_byte(input logic [7:0] d, input bit ok);
      if (!ok) begin
         exp_err++;
         mpos = 0;
      end else if (mpos == 0) begin
         if (d[3]) begin
            mb1 = d;
            mpos = 1;
         end else exp_err++;
      end else if (mpos == 1) begin
         mbx = d;
         mpos = 2;
      end else begin
         exp_done++;
         exp_x = delta(mb1[6], mb1[4], mbx);
         exp_y = delta(mb1[7], mb1[5], d);
         exp_btn = {mb1[2], mb1[1], mb1[0]};
         mpos = 0;
      end
   endfunction

   task automatic check_state(input string tag);
      check({tag, ".err"}, err_cnt, exp_err);
      check({tag, ".done"}, done_cnt, exp_done);
      check({tag, ".xm"}, {23'd0, xm}, {23'd0, exp_x});
      check({tag, ".ym"}, {23'd0, ym}, {23'd0, exp_y});
      check({tag, ".btn"}, {29'd0, middle, right, left}, {29'd0, exp_btn});
   endtask

   task automatic send_bits(input logic [10:0] f, input int nb);
      for (int i = 0; i < nb; i++) begin
         ps2d = f[i];
         tick(HP);
         ps2c = 1'b0;
         tick(HP);
         ps2c = 1'b1;
      end
      ps2d = 1'b1;
      tick(GAP);
   endtask

   task automatic send(input string tag, input logic [7:0] d, input bit bad_par, input bit bad_stop);
      bit ok;
      send_bits({~bad_stop, (~^d) ^ bad_par, d, 1'b0}, 11);
`ifdef PS2_PARITY_CHECK_EN
      ok = !bad_stop && !bad_par;
`else
      ok = !bad_stop;
`endif
      if (rx_en) model_byte(d, ok);
      check_state(tag);
   endtask

   task automatic wait_timeout(input string tag);
      tick(TO + 300);
      exp_err++;
      mpos = 0;
      check_state(tag);
   endtask

   initial begin
      logic [7:0] d;
      tick(5);
      reset = 1'b0;
      tick(20);
      check_state("reset");

      send("p1a", 8'h09, 0, 0); send("p1b", 8'h05, 0, 0); send("p1c", 8'hFE, 0, 0);
      send("p2a", 8'h28, 0, 0); send("p2b", 8'h10, 0, 0); send("p2c", 8'hF0, 0, 0);
      send("sync", 8'h00, 0, 0);
      send("p3a", 8'h0A, 0, 0); send("p3b", 8'h01, 0, 0); send("p3c", 8'h02, 0, 0);
      send("ovxa", 8'h48, 0, 0); send("ovxb", 8'h12, 0, 0); send("ovxc", 8'h00, 0, 0);
      send("ovna", 8'h58, 0, 0); send("ovnb", 8'h00, 0, 0); send("ovnc", 8'h00, 0, 0);
      send("ovya", 8'hB8, 0, 0); send("ovyb", 8'h7F, 0, 0); send("ovyc", 8'h33, 0, 0);

      send("toa", 8'h08, 0, 0); send("tob", 8'h77, 0, 0);
      wait_timeout("to");
      send("p4a", 8'h08, 0, 0); send("p4b", 8'h03, 0, 0); send("p4c", 8'h04, 0, 0);

      send("para", 8'h08, 0, 0); send("parb", 8'h11, 1, 0); send("parc", 8'h22, 0, 0);
      send("stop", 8'h09, 0, 1);

      send_bits({2'b11, 8'hA5, 1'b0}, 4);
      wait_timeout("to_bits");

      send("rxa", 8'h0C, 0, 0);
      rx_en = 1'b0;
      send("rx_off", 8'h08, 0, 0);
      wait_timeout("to_rx");
      rx_en = 1'b1;

      send("rsa", 8'h09, 0, 0); send("rsb", 8'h44, 0, 0);
      send_bits({2'b11, 8'h55, 1'b0}, 6);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      exp_x = '0; exp_y = '0; exp_btn = '0; mpos = 0;
      tick(20);
      check_state("rst_mid");
      send("p5a", 8'h0F, 0, 0); send("p5b", 8'h81, 0, 0); send("p5c", 8'h7E, 0, 0);

      for (int i = 0; i < 45; i++) begin
         d = 8'($urandom);
         if (mpos == 0 && $urandom_range(0, 3) != 0) d[3] = 1'b1;
         send("rand", d, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
